// File: rtl/mux4_arbiter.sv
// Round-robin arbiter sharing a 4:1 one-bit mux among four requesters,
// with a bounded hold time per grant and zero-bubble handover.

module multiplexor4to1 (
  input  logic [3:0] in,
  input  logic [1:0] select,
  output logic       out
);

  always_comb begin
    case (select)
      2'd0:    out = in[0];
      2'd1:    out = in[1];
      2'd2:    out = in[2];
      2'd3:    out = in[3];
      default: out = 1'b0;
    endcase
  end

endmodule

module mux4_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  input  logic [3:0] in,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       valid,
  output logic       out
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [1:0]    ptr;
  logic [1:0]    ptr_n;
  logic [1:0]    select_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [1:0]    idx;
  logic [1:0]    winner;
  logic          found;
  logic          release_hold;
  logic          mux_out;

  // Search starts at ptr, which already points one past the last holder,
  // so the previous holder is only picked when nobody else is asking.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end else begin
        found = found;
      end
    end
  end

  always_comb begin
    state_n      = state;
    select_n     = select;
    ptr_n        = ptr;
    cnt_n        = cnt;
    release_hold = done || !req[select] || (cnt == CW'(MAX_HOLD));
    case (state)
      IDLE: begin
        if (found) begin
          state_n  = GRANT;
          select_n = winner;
          ptr_n    = winner + 2'd1;
          cnt_n    = CW'(1);
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (!release_hold) begin
          cnt_n = cnt + CW'(1);
        end else if (found) begin
          state_n  = GRANT;
          select_n = winner;
          ptr_n    = winner + 2'd1;
          cnt_n    = CW'(1);
        end else begin
          state_n = IDLE;
          cnt_n   = {CW{1'b0}};
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      select <= 2'd0;
      ptr    <= 2'd0;
      cnt    <= {CW{1'b0}};
    end else begin
      state  <= state_n;
      select <= select_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
    end
  end

  multiplexor4to1 u_mux (
    .in     (in),
    .select (select),
    .out    (mux_out)
  );

  assign valid = (state == GRANT);
  assign grant = valid ? (4'b0001 << select) : 4'b0000;
  assign out   = valid & mux_out;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Bench for mux4_arbiter: directed scenarios plus random traffic, all
// compared cycle by cycle against a simple round-robin reference model.

module tb_mux4_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] in = 4'b0000;
  logic [3:0] grant;
  logic [1:0] select;
  logic       valid;
  logic       out;

  int checks = 0;
  int errors = 0;

  // reference model: who holds the channel, for how long, where search starts
  bit m_valid = 1'b0;
  int m_sel   = 0;
  int m_start = 0;
  int m_cnt   = 0;

  mux4_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .done   (done),
    .in     (in),
    .grant  (grant),
    .select (select),
    .valid  (valid),
    .out    (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input logic [3:0] q, input bit d);
    bit keep;
    int w;
    if (r) begin
      m_valid = 1'b0;
      m_sel   = 0;
      m_start = 0;
      m_cnt   = 0;
    end else begin
      keep = m_valid && !d && q[m_sel] && (m_cnt < MAXH);
      if (keep) begin
        m_cnt++;
      end else begin
        w = -1;
        for (int j = 0; j < 4; j++)
          if (w < 0 && q[(m_start + j) % 4]) w = (m_start + j) % 4;
        if (w >= 0) begin
          m_valid = 1'b1;
          m_sel   = w;
          m_start = (w + 1) % 4;
          m_cnt   = 1;
        end else begin
          m_valid = 1'b0;
          m_cnt   = 0;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic [3:0] eg;
    logic [3:0] iv;
    eg = m_valid ? (4'(1) << m_sel) : 4'b0000;
    iv = in;
    check("valid", valid, m_valid);
    check("grant", grant, eg);
    check("select", select, m_sel[1:0]);
    check("out", out, m_valid ? iv[m_sel] : 1'b0);
  endtask

  // one clock: drive at negedge, model at posedge, compare just after
  task automatic cyc(input bit r, input logic [3:0] q, input bit d);
    @(negedge clk);
    reset = r;
    req   = q;
    done  = d;
    in    = 4'($urandom);
    @(posedge clk);
    model_edge(r, q, d);
    #1;
    compare_outputs();
    in = 4'($urandom);
    #1;
    check("out_comb", out, m_valid ? in[m_sel] : 1'b0);
  endtask

  initial begin
    logic [3:0] rr_exp [5];
    rr_exp[0] = 4'b0010; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b1000;
    rr_exp[3] = 4'b0001; rr_exp[4] = 4'b0010;

    // reset dominates req and done
    cyc(1'b1, 4'b1111, 1'b1);
    check("rst_grant", grant, 4'b0000);
    check("rst_valid", valid, 1'b0);
    check("rst_select", select, 2'd0);
    check("rst_out", out, 1'b0);
    cyc(1'b0, 4'b1111, 1'b0);
    check("first_grant", grant, 4'b0001);

    // round robin with done on every granted cycle
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 4'b1111, 1'b1);
      check("rr_grant", grant, rr_exp[i]);
    end

    // single requester, then drop
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0);
    check("single_grant", grant, 4'b0100);
    check("single_select", select, 2'd2);
    cyc(1'b0, 4'b0000, 1'b0);
    check("single_drop", valid, 1'b0);

    // timeout alternation between 0 and 1
    cyc(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 4'b0011, 1'b0);
      check("timeout_grant", grant, ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 4'b0001, 1'b0);
      check("sole_regrant", grant, 4'b0001);
    end

    // holder 1 releases while its req drops and others are pending
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0010, 1'b0);
    check("sim_holder", grant, 4'b0010);
    cyc(1'b0, 4'b1101, 1'b1);
    check("sim_next", grant, 4'b0100);
    cyc(1'b0, 4'b1101, 1'b1);
    check("sim_ptr3", grant, 4'b1000);

    // reset mid-grant clears ptr
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b1000, 1'b0);
    cyc(1'b0, 4'b1000, 1'b0);
    check("mid_holder", grant, 4'b1000);
    cyc(1'b1, 4'b1111, 1'b1);
    check("mid_rst_grant", grant, 4'b0000);
    check("mid_rst_out", out, 1'b0);
    cyc(1'b0, 4'b1001, 1'b0);
    check("mid_ptr_zero", grant, 4'b0001);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0), 4'($urandom), ($urandom_range(3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
